// File: rtl/fetch_prefetch_buffer_if.sv
// Signal bundle between the fetch stage, instruction memory and the core front end.
// The master side is the fetch stage; the slave side is the environment around it.
interface fetch_prefetch_buffer_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic          redirect_valid;
   logic [31:0]   redirect_pc;
   logic          imem_req;
   logic [31:0]   imem_addr;
   logic          imem_gnt;
   logic          imem_rvalid;
   logic [31:0]   imem_rdata;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_pc;
   logic [31:0]   out_instruction;
   logic [CW-1:0] fill_level;

   modport master (
      input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
      output imem_req, imem_addr, out_valid, out_pc, out_instruction, fill_level
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
      input  imem_req, imem_addr, out_valid, out_pc, out_instruction, fill_level
   );
endinterface

// File: rtl/fetch_prefetch_buffer.sv
// Instruction fetch stage: one outstanding word read at a time, results queued as
// {pc, instruction} pairs in a DEPTH-entry FIFO; a redirect flushes and restarts fetch.
module fetch_prefetch_buffer #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic                     clk,
   input logic                     reset,
   fetch_prefetch_buffer_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t        state;
   logic          req_q;
   logic          discard;
   logic [31:0]   fetch_pc;
   logic [31:0]   req_addr;
   logic [31:0]   inflight_pc;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [31:0]   pc_mem  [DEPTH];
   logic [31:0]   ins_mem [DEPTH];

   logic [31:0]   redir_pc;
   logic [CW-1:0] count_next;
   logic          rsp;
   logic          gnt_acc;
   logic          push;
   logic          pop;
   logic          go_req;

   // A redirect wins over everything: it blocks both the push of a same-cycle
   // response and the pop of the current head.
   always_comb begin
      redir_pc   = bus.redirect_pc & ~32'h3;
      rsp        = (state == WAIT) && bus.imem_rvalid;
      gnt_acc    = (state == REQ) && bus.imem_gnt;
      push       = rsp && !discard && !bus.redirect_valid;
      pop        = (count != '0) && bus.out_ready && !bus.redirect_valid;
      count_next = count + CW'(push) - CW'(pop);
      go_req     = ((state == IDLE) && (bus.redirect_valid || (count < CW'(DEPTH)))) ||
                   (rsp && (bus.redirect_valid || (count_next < CW'(DEPTH))));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         req_q    <= 1'b0;
         discard  <= 1'b0;
         fetch_pc <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         if (bus.redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_next;
         end

         // A stale request (discard set while in REQ) must not advance the new fetch_pc.
         if (bus.redirect_valid)      fetch_pc <= redir_pc;
         else if (gnt_acc && !discard) fetch_pc <= fetch_pc + 32'd4;

         if (rsp)                                         discard <= 1'b0;
         else if (bus.redirect_valid && (state != IDLE)) discard <= 1'b1;

         case (state)
            IDLE: if (go_req) begin
               state <= REQ;
               req_q <= 1'b1;
            end
            REQ: if (bus.imem_gnt) begin
               state <= WAIT;
               req_q <= 1'b0;
            end
            WAIT: if (bus.imem_rvalid) begin
               state <= go_req ? REQ : IDLE;
               req_q <= go_req;
            end
            default: begin
               state <= IDLE;
               req_q <= 1'b0;
            end
         endcase
      end
   end

   // Datapath registers carry no reset; they are only observed under valid control.
   always_ff @(posedge clk) begin
      if (go_req)  req_addr    <= bus.redirect_valid ? redir_pc : fetch_pc;
      if (gnt_acc) inflight_pc <= req_addr;
      if (push) begin
         pc_mem[wr_ptr]  <= inflight_pc;
         ins_mem[wr_ptr] <= bus.imem_rdata;
      end
   end

   assign bus.imem_req        = req_q;
   assign bus.imem_addr       = req_addr;
   assign bus.out_valid       = (count != '0);
   assign bus.out_pc          = pc_mem[rd_ptr];
   assign bus.out_instruction = ins_mem[rd_ptr];
   assign bus.fill_level      = count;
endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Randomized bench for fetch_prefetch_buffer: a memory responder plus a reference model
// that expects sequential word PCs from the last reset/redirect, delivered in order.
`timescale 1ns/1ps
module tb_fetch_prefetch_buffer;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          CW       = $clog2(DEPTH + 1);

   logic clk = 1'b0;
   logic reset;

   fetch_prefetch_buffer_if #(.DEPTH(DEPTH)) bus ();

   fetch_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int          gnt_pct, ready_pct, lat_min, lat_max, redir_pct, spur_pct;
   bit          gnt_block, redir_now;
   logic [31:0] redir_addr;

   bit          pend, pend_stale, req_stale, last_gnt;
   int          pend_wait;
   logic [31:0] pend_addr, pend_exp, exp_fetch;
   logic [31:0] q[$];
   int          pops;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
   endfunction

   // Drive one cycle of inputs, advance the memory responder and the reference model,
   // and return at the following negedge.
   task automatic tick();
      logic        gnt, rv, rdy, rd, real_rsp;
      logic [31:0] rpc;
      gnt      = reset && !pend && !gnt_block && (bus.imem_req === 1'b1) &&
                 ($urandom_range(99) < gnt_pct);
      real_rsp = pend && (pend_wait == 0);
      rv       = real_rsp || (!pend && ($urandom_range(99) < spur_pct));
      rdy      = $urandom_range(99) < ready_pct;
      rd       = reset && (redir_now || ($urandom_range(99) < redir_pct));
      rpc      = redir_now ? redir_addr : $urandom;
      bus.imem_gnt       = gnt;
      bus.imem_rvalid    = rv;
      bus.imem_rdata     = real_rsp ? instr_of(pend_addr) : $urandom;
      bus.out_ready      = rdy;
      bus.redirect_valid = rd;
      bus.redirect_pc    = rpc;
      last_gnt           = gnt;

      if (!reset) begin
         q.delete();
         exp_fetch  = RESET_PC;
         req_stale  = 1'b0;
         pend_stale = 1'b1;
         if (real_rsp) pend = 1'b0;
         else if (pend) pend_wait--;
      end else begin
         if ((q.size() != 0) && rdy && !rd) begin
            void'(q.pop_front());
            pops++;
         end
         if (real_rsp && !pend_stale && !rd) q.push_back(pend_exp);
         if (real_rsp) pend = 1'b0;
         else if (pend) pend_wait--;
         if (rd) begin
            q.delete();
            pend_stale = 1'b1;
            if ((bus.imem_req === 1'b1) && !gnt) req_stale = 1'b1;
         end
         if (gnt) begin
            pend       = 1'b1;
            pend_addr  = bus.imem_addr;
            pend_wait  = int'($urandom_range(lat_max, lat_min)) - 1;
            pend_stale = req_stale || rd;
            req_stale  = 1'b0;
            if (!pend_stale) begin
               pend_exp  = exp_fetch;
               exp_fetch = exp_fetch + 32'd4;
            end
         end
         if (rd) exp_fetch = rpc & ~32'h3;
      end
      @(negedge clk);
   endtask

   task automatic knobs(input int g, input int r, input int lmin, input int lmax);
      gnt_pct = g; ready_pct = r; lat_min = lmin; lat_max = lmax;
      redir_pct = 0; spur_pct = 0; gnt_block = 1'b0; redir_now = 1'b0;
   endtask

   task automatic test_reset();
      knobs(100, 100, 1, 1);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", bus.imem_req); end
         checks++;
         if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
         checks++;
         if (bus.fill_level !== '0) begin errors++; $display("FAIL reset_fill got %0d want 0", bus.fill_level); end
      end
      reset = 1'b1;
   endtask

   task automatic test_stream();
      knobs(100, 100, 1, 1);
      pops = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         checks++;
         if (bus.fill_level !== CW'(q.size())) begin errors++; $display("FAIL stream_fill got %0d want %0d", bus.fill_level, q.size()); end
         checks++;
         if (bus.out_valid !== (q.size() != 0)) begin errors++; $display("FAIL stream_valid got %b want %b", bus.out_valid, q.size() != 0); end
         if (q.size() != 0) begin
            checks++;
            if ((bus.out_pc !== q[0]) || (bus.out_instruction !== instr_of(q[0])))
               begin errors++; $display("FAIL stream_head got %h/%h want %h/%h", bus.out_pc, bus.out_instruction, q[0], instr_of(q[0])); end
         end
      end
      checks++;
      if (pops < 10) begin errors++; $display("FAIL stream_progress got %0d pops want >=10", pops); end
   endtask

   task automatic test_full();
      knobs(100, 0, 1, 1);
      for (int i = 0; i < 20; i++) tick();
      checks++;
      if (bus.fill_level !== CW'(DEPTH)) begin errors++; $display("FAIL full_fill got %0d want %0d", bus.fill_level, DEPTH); end
      checks++;
      if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL full_req got %b want 0", bus.imem_req); end
      checks++;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL full_valid got %b want 1", bus.out_valid); end
      ready_pct = 100;
      for (int i = 0; i < 30; i++) begin
         tick();
         checks++;
         if (bus.fill_level !== CW'(q.size())) begin errors++; $display("FAIL drain_fill got %0d want %0d", bus.fill_level, q.size()); end
         if (q.size() != 0) begin
            checks++;
            if ((bus.out_pc !== q[0]) || (bus.out_instruction !== instr_of(q[0])))
               begin errors++; $display("FAIL drain_head got %h/%h want %h/%h", bus.out_pc, bus.out_instruction, q[0], instr_of(q[0])); end
         end
      end
   endtask

   task automatic test_redirect_wait();
      int n;
      knobs(100, 100, 3, 3);
      n = 0;
      while (!(pend && (pend_wait >= 1)) && (n < 20)) begin tick(); n++; end
      checks++;
      if (!(pend && (pend_wait >= 1))) begin errors++; $display("FAIL rwait_setup got timeout want WAIT"); end
      redir_now = 1'b1; redir_addr = 32'h0000_0100;
      tick();
      redir_now = 1'b0;
      checks++;
      if ((bus.fill_level !== '0) || (bus.out_valid !== 1'b0))
         begin errors++; $display("FAIL rwait_flush got %0d/%b want 0/0", bus.fill_level, bus.out_valid); end
      n = 0;
      while ((bus.out_valid !== 1'b1) && (n < 20)) begin tick(); n++; end
      checks++;
      if ((bus.out_pc !== 32'h100) || (bus.out_instruction !== instr_of(32'h100)))
         begin errors++; $display("FAIL rwait_first got %h/%h want 00000100/%h", bus.out_pc, bus.out_instruction, instr_of(32'h100)); end
   endtask

   task automatic test_redirect_stall();
      int          n;
      logic [31:0] held;
      knobs(100, 100, 1, 1);
      gnt_block = 1'b1;
      n = 0;
      while (!((bus.imem_req === 1'b1) && !pend) && (n < 20)) begin tick(); n++; end
      checks++;
      if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL rstall_setup got timeout want REQ"); end
      held = bus.imem_addr;
      redir_now = 1'b1; redir_addr = 32'h0000_0203;
      for (int i = 0; i < 3; i++) begin
         tick();
         redir_now = 1'b0;
         checks++;
         if ((bus.imem_req !== 1'b1) || (bus.imem_addr !== held))
            begin errors++; $display("FAIL rstall_hold got %b/%h want 1/%h", bus.imem_req, bus.imem_addr, held); end
      end
      gnt_block = 1'b0;
      n = 0;
      while (!pend && (n < 10)) begin tick(); n++; end
      n = 0;
      while ((bus.imem_req !== 1'b1) && (n < 10)) begin tick(); n++; end
      checks++;
      if ((bus.imem_req !== 1'b1) || (bus.imem_addr !== 32'h200))
         begin errors++; $display("FAIL rstall_next got %b/%h want 1/00000200", bus.imem_req, bus.imem_addr); end
      checks++;
      if (bus.fill_level !== '0) begin errors++; $display("FAIL rstall_drop got %0d want 0", bus.fill_level); end
   endtask

   task automatic test_redirect_rvalid_pop();
      int          n;
      logic [31:0] a;
      knobs(100, 0, 1, 1);
      n = 0;
      while (!((q.size() != 0) && pend && (pend_wait == 0)) && (n < 30)) begin tick(); n++; end
      checks++;
      if (!((q.size() != 0) && pend)) begin errors++; $display("FAIL rboth_setup got timeout want WAIT with data"); end
      a = $urandom;
      a = a & 32'h00FF_FFFC;
      ready_pct = 100; redir_now = 1'b1; redir_addr = a;
      tick();
      redir_now = 1'b0;
      checks++;
      if ((bus.fill_level !== '0) || (bus.out_valid !== 1'b0))
         begin errors++; $display("FAIL rboth_flush got %0d/%b want 0/0", bus.fill_level, bus.out_valid); end
      n = 0;
      while ((bus.out_valid !== 1'b1) && (n < 10)) begin tick(); n++; end
      checks++;
      if (bus.out_pc !== a) begin errors++; $display("FAIL rboth_first got %h want %h", bus.out_pc, a); end
   endtask

   task automatic test_reset_mid_wait();
      int n;
      knobs(100, 0, 2, 3);
      n = 0;
      while (!((q.size() == 3) && pend && (pend_wait >= 1)) && (n < 40)) begin tick(); n++; end
      checks++;
      if (bus.fill_level !== CW'(3)) begin errors++; $display("FAIL rmid_setup got %0d want 3", bus.fill_level); end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      checks++;
      if ((bus.imem_req !== 1'b0) || (bus.out_valid !== 1'b0) || (bus.fill_level !== '0))
         begin errors++; $display("FAIL rmid_reset got %b/%b/%0d want 0/0/0", bus.imem_req, bus.out_valid, bus.fill_level); end
      n = 0;
      while ((bus.imem_req !== 1'b1) && (n < 20)) begin tick(); n++; end
      checks++;
      if (bus.imem_addr !== RESET_PC) begin errors++; $display("FAIL rmid_addr got %h want %h", bus.imem_addr, RESET_PC); end
      ready_pct = 100;
      n = 0;
      while ((bus.out_valid !== 1'b1) && (n < 20)) begin tick(); n++; end
      checks++;
      if ((bus.out_pc !== RESET_PC) || (bus.out_instruction !== instr_of(RESET_PC)))
         begin errors++; $display("FAIL rmid_first got %h/%h want %h/%h", bus.out_pc, bus.out_instruction, RESET_PC, instr_of(RESET_PC)); end
   endtask

   task automatic test_pc_wrap();
      knobs(100, 100, 1, 1);
      redir_now = 1'b1; redir_addr = 32'hFFFF_FFF9;
      tick();
      redir_now = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (q.size() != 0) begin
            checks++;
            if ((bus.out_pc !== q[0]) || (bus.out_instruction !== instr_of(q[0])))
               begin errors++; $display("FAIL wrap_head got %h want %h", bus.out_pc, q[0]); end
         end
      end
   endtask

   task automatic test_random();
      bit          p_req, p_gnt;
      logic [31:0] p_addr;
      knobs(60, 60, 1, 3);
      redir_pct = 3; spur_pct = 10;
      for (int i = 0; i < 1500; i++) begin
         if ((i % 250) == 0) ready_pct = int'($urandom_range(100, 10));
         p_req  = (bus.imem_req === 1'b1);
         p_addr = bus.imem_addr;
         tick();
         p_gnt  = last_gnt;
         if (p_req && !p_gnt) begin
            checks++;
            if ((bus.imem_req !== 1'b1) || (bus.imem_addr !== p_addr))
               begin errors++; $display("FAIL rand_req_hold got %b/%h want 1/%h", bus.imem_req, bus.imem_addr, p_addr); end
         end
         checks++;
         if (bus.fill_level !== CW'(q.size())) begin errors++; $display("FAIL rand_fill got %0d want %0d", bus.fill_level, q.size()); end
         checks++;
         if (bus.out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rand_valid got %b want %b", bus.out_valid, q.size() != 0); end
         if (q.size() != 0) begin
            checks++;
            if ((bus.out_pc !== q[0]) || (bus.out_instruction !== instr_of(q[0])))
               begin errors++; $display("FAIL rand_head got %h/%h want %h/%h", bus.out_pc, bus.out_instruction, q[0], instr_of(q[0])); end
         end
      end
   endtask

   initial begin
      reset              = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.imem_gnt       = 1'b0;
      bus.imem_rvalid    = 1'b0;
      bus.imem_rdata     = '0;
      bus.out_ready      = 1'b0;
      pend = 1'b0; pend_stale = 1'b0; req_stale = 1'b0; last_gnt = 1'b0;
      pend_wait = 0; pend_addr = '0; pend_exp = '0; exp_fetch = RESET_PC; pops = 0;
      redir_addr = '0;
      knobs(100, 100, 1, 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      test_reset();
      test_stream();
      test_full();
      test_redirect_wait();
      test_redirect_stall();
      test_redirect_rvalid_pop();
      test_reset_mid_wait();
      test_pc_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
